hsv_blob_track: RTL

HSV_BLOB_TRACK -- requirements
Module: hsv_blob_track

---
 rtl/hsv_blob_track.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/hsv_blob_track.sv
// HSV window mask plus per-frame bounding box and pixel count of the matched region.
// Define HSV_BLOB_CENTROID_EN to add saturating coordinate sums (sum_x, sum_y) for centroids.
module hsv_blob_track #(
  parameter int unsigned IMG_W    = 640,
  parameter int unsigned IMG_H    = 480,
  parameter int unsigned SYNC_DLY = 3,
  parameter int unsigned MIN_PIX  = 64
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        vsync_in,
  input  logic        de_in,
  input  logic [23:0] hsv24,
  input  logic [7:0]  h_lo,
  input  logic [7:0]  h_hi,
  input  logic [7:0]  s_lo,
  input  logic [7:0]  v_lo,
  output logic        mask_out,
  output logic        mask_de,
  output logic        blob_valid,
  output logic        blob_found,
  output logic [9:0]  x_min,
  output logic [9:0]  x_max,
  output logic [9:0]  y_min,
  output logic [9:0]  y_max,
  output logic [18:0] pix_cnt
`ifdef HSV_BLOB_CENTROID_EN
  ,
  output logic [28:0] sum_x,
  output logic [27:0] sum_y
`endif
);

  localparam logic [1:0]  WAIT_FRAME = 2'd0;
  localparam logic [1:0]  ACCUM      = 2'd1;
  localparam logic [1:0]  REPORT     = 2'd2;
  localparam logic [9:0]  X_LAST     = 10'(IMG_W - 1);
  localparam logic [9:0]  Y_LAST     = 10'(IMG_H - 1);
  localparam logic [18:0] CNT_MAX    = '1;
  localparam logic [18:0] MIN_CNT    = 19'(MIN_PIX);

  logic [SYNC_DLY-1:0] de_sr, vs_sr;
  logic                de_d, vs_d, de_q, vs_q;
  logic                vs_fall, vs_rise, de_fall;
  logic [1:0]          state;
  logic [9:0]          x_cnt, y_cnt;
  logic [9:0]          xmin_r, xmax_r, ymin_r, ymax_r;
  logic [9:0]          xmin_n, xmax_n, ymin_n, ymax_n;
  logic [18:0]         cnt_r, cnt_n;
  logic [7:0]          h, s, v;
  logic                hue_ok, match, pix_hit, found_n;

  if (SYNC_DLY > 1) begin : g_sync_multi
    always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
        de_sr <= '0;
        vs_sr <= '0;
      end else begin
        de_sr <= {de_sr[SYNC_DLY-2:0], de_in};
        vs_sr <= {vs_sr[SYNC_DLY-2:0], vsync_in};
      end
    end
  end else begin : g_sync_one
    always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
        de_sr <= '0;
        vs_sr <= '0;
      end else begin
        de_sr <= de_in;
        vs_sr <= vsync_in;
      end
    end
  end

  assign de_d    = de_sr[SYNC_DLY-1];
  assign vs_d    = vs_sr[SYNC_DLY-1];
  assign vs_fall = ~vs_d & vs_q;
  assign vs_rise = vs_d & ~vs_q;
  assign de_fall = ~de_d & de_q;

  assign h = hsv24[23:16];
  assign s = hsv24[15:8];
  assign v = hsv24[7:0];
  // A reversed hue window selects the band that wraps through 0/179.
  assign hue_ok  = (h_lo <= h_hi) ? ((h >= h_lo) && (h <= h_hi))
                                  : ((h >= h_lo) || (h <= h_hi));
  assign match   = hue_ok && (s >= s_lo) && (v >= v_lo);
  assign pix_hit = match && de_d && (state == ACCUM);

`ifdef HSV_BLOB_CENTROID_EN
  logic [28:0] sx_r, sx_n;
  logic [27:0] sy_r, sy_n;
  logic [29:0] sx_sum;
  logic [28:0] sy_sum;
  assign sx_sum = {1'b0, sx_r} + {20'd0, x_cnt};
  assign sy_sum = {1'b0, sy_r} + {19'd0, y_cnt};
`endif

  // Next-state accumulators, so a pixel coinciding with the frame-end edge is still reported.
  always_comb begin
    xmin_n = xmin_r;
    xmax_n = xmax_r;
    ymin_n = ymin_r;
    ymax_n = ymax_r;
    cnt_n  = cnt_r;
`ifdef HSV_BLOB_CENTROID_EN
    sx_n   = sx_r;
    sy_n   = sy_r;
`endif
    if (pix_hit) begin
      if (x_cnt < xmin_r) xmin_n = x_cnt;
      if (x_cnt > xmax_r) xmax_n = x_cnt;
      if (y_cnt < ymin_r) ymin_n = y_cnt;
      if (y_cnt > ymax_r) ymax_n = y_cnt;
      if (cnt_r != CNT_MAX) cnt_n = cnt_r + 19'd1;
`ifdef HSV_BLOB_CENTROID_EN
      sx_n = sx_sum[29] ? '1 : sx_sum[28:0];
      sy_n = sy_sum[28] ? '1 : sy_sum[27:0];
`endif
    end
  end

  assign found_n = (cnt_n >= MIN_CNT);

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WAIT_FRAME;
      vs_q       <= 1'b0;
      de_q       <= 1'b0;
      x_cnt      <= '0;
      y_cnt      <= '0;
      xmin_r     <= '0;
      xmax_r     <= '0;
      ymin_r     <= '0;
      ymax_r     <= '0;
      cnt_r      <= '0;
      mask_out   <= 1'b0;
      mask_de    <= 1'b0;
      blob_valid <= 1'b0;
      blob_found <= 1'b0;
      x_min      <= '0;
      x_max      <= '0;
      y_min      <= '0;
      y_max      <= '0;
      pix_cnt    <= '0;
`ifdef HSV_BLOB_CENTROID_EN
      sx_r       <= '0;
      sy_r       <= '0;
      sum_x      <= '0;
      sum_y      <= '0;
`endif
    end else begin
      vs_q       <= vs_d;
      de_q       <= de_d;
      mask_out   <= match & de_d;
      mask_de    <= de_d;
      blob_valid <= 1'b0;

      if (vs_fall) begin
        x_cnt <= '0;
        y_cnt <= '0;
      end else if (de_d) begin
        if (x_cnt != X_LAST) x_cnt <= x_cnt + 10'd1;
      end else if (de_fall) begin
        x_cnt <= '0;
        if (y_cnt != Y_LAST) y_cnt <= y_cnt + 10'd1;
      end

      case (state)
        WAIT_FRAME: begin
          if (vs_fall) begin
            state  <= ACCUM;
            xmin_r <= X_LAST;
            xmax_r <= '0;
            ymin_r <= Y_LAST;
            ymax_r <= '0;
            cnt_r  <= '0;
`ifdef HSV_BLOB_CENTROID_EN
            sx_r   <= '0;
            sy_r   <= '0;
`endif
          end
        end
        ACCUM: begin
          xmin_r <= xmin_n;
          xmax_r <= xmax_n;
          ymin_r <= ymin_n;
          ymax_r <= ymax_n;
          cnt_r  <= cnt_n;
`ifdef HSV_BLOB_CENTROID_EN
          sx_r   <= sx_n;
          sy_r   <= sy_n;
`endif
          if (vs_rise) begin
            state      <= REPORT;
            blob_valid <= 1'b1;
            blob_found <= found_n;
            x_min      <= found_n ? xmin_n : '0;
            x_max      <= found_n ? xmax_n : '0;
            y_min      <= found_n ? ymin_n : '0;
            y_max      <= found_n ? ymax_n : '0;
            pix_cnt    <= cnt_n;
`ifdef HSV_BLOB_CENTROID_EN
            sum_x      <= sx_n;
            sum_y      <= sy_n;
`endif
          end
        end
        REPORT:  state <= WAIT_FRAME;
        default: state <= WAIT_FRAME;
      endcase
    end
  end

endmodule
